// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
//
// Shares one single-ported BRAM between two requesters: the AXI-side BRAM
// controller (bc_*) and the FC sequencer (fc_*). Ownership is granted one
// tenure at a time. A tenure is cut after MAX_BURST accepted beats, but only
// while the other side is waiting. Reads return one cycle after acceptance.
// The read data is routed to the side that issued the read, even if ownership
// has moved on in the meantime.
//
// Ports
//   clk, rst                    : clock, synchronous active-high reset
//   bc_en/we/addr/din           : BRAM-controller access request (we==0 -> read)
//   bc_ready                    : BRAM controller currently owns the port
//   bc_rvld/bc_dout             : BRAM-controller read response
//   fc_* (same set)             : FC-sequencer side
//   bram_en/we/addr/din         : shared BRAM port (zero when no access)
//   bram_dout                   : shared BRAM read data, 1-cycle latency
//   owner                       : 00 idle, 01 bc, 10 fc
// -----------------------------------------------------------------------------
module bram_port_arbiter #(
  parameter int BRAM_DAT_W  = 64,
  parameter int BRAM_ADDR_W = 32,
  parameter int MAX_BURST   = 16
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   bc_en,
  input  logic [7:0]             bc_we,
  input  logic [BRAM_ADDR_W-1:0] bc_addr,
  input  logic [BRAM_DAT_W-1:0]  bc_din,
  output logic                   bc_ready,
  output logic                   bc_rvld,
  output logic [BRAM_DAT_W-1:0]  bc_dout,

  input  logic                   fc_en,
  input  logic [7:0]             fc_we,
  input  logic [BRAM_ADDR_W-1:0] fc_addr,
  input  logic [BRAM_DAT_W-1:0]  fc_din,
  output logic                   fc_ready,
  output logic                   fc_rvld,
  output logic [BRAM_DAT_W-1:0]  fc_dout,

  output logic                   bram_en,
  output logic [7:0]             bram_we,
  output logic [BRAM_ADDR_W-1:0] bram_addr,
  output logic [BRAM_DAT_W-1:0]  bram_din,
  input  logic [BRAM_DAT_W-1:0]  bram_dout,

  output logic [1:0]             owner
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  // State encoding doubles as the owner output.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    OWN_BC = 2'b01,
    OWN_FC = 2'b10
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_burst_cnt;
  logic             r_last_fc;    // 1: fc was the last owner, 0: bc was
  logic             r_rd_bc_p1;   // read tag: bc read accepted last cycle
  logic             r_rd_fc_p1;   // read tag: fc read accepted last cycle

  logic w_acc_bc;
  logic w_acc_fc;
  logic w_cnt_last;

  assign w_acc_bc   = (r_state == OWN_BC) && bc_en;
  assign w_acc_fc   = (r_state == OWN_FC) && fc_en;
  assign w_cnt_last = (r_burst_cnt == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Ownership FSM. burst_cnt clears on every state change and parks at
  // MAX_BURST-1 while the other side is idle, so an uncontested tenure is
  // unlimited and a newly arriving competitor waits at most one more beat.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_burst_cnt <= '0;
      r_last_fc   <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_burst_cnt <= '0;
          // On a tie, the side that did not own the port last time wins.
          if (bc_en && (!fc_en || r_last_fc)) begin
            r_state <= OWN_BC;
          end else if (fc_en) begin
            r_state <= OWN_FC;
          end
        end

        OWN_BC: begin
          if (!bc_en) begin
            r_last_fc   <= 1'b0;
            r_burst_cnt <= '0;
            r_state     <= fc_en ? OWN_FC : IDLE;
          end else if (w_cnt_last && fc_en) begin
            // Final beat of a contested tenure: accept it, then hand over.
            r_last_fc   <= 1'b0;
            r_burst_cnt <= '0;
            r_state     <= OWN_FC;
          end else if (!w_cnt_last) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
          end
        end

        OWN_FC: begin
          if (!fc_en) begin
            r_last_fc   <= 1'b1;
            r_burst_cnt <= '0;
            r_state     <= bc_en ? OWN_BC : IDLE;
          end else if (w_cnt_last && bc_en) begin
            r_last_fc   <= 1'b1;
            r_burst_cnt <= '0;
            r_state     <= OWN_BC;
          end else if (!w_cnt_last) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_burst_cnt <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p0 -> p1: read tag captured at acceptance. Reset discards a read
  // accepted in the same cycle so no response escapes after reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_bc_p1 <= 1'b0;
      r_rd_fc_p1 <= 1'b0;
    end else begin
      r_rd_bc_p1 <= w_acc_bc && (bc_we == 8'h00);
      r_rd_fc_p1 <= w_acc_fc && (fc_we == 8'h00);
    end
  end

  // Shared-port mux: only an accepted access reaches the BRAM.
  always_comb begin
    bram_en   = 1'b0;
    bram_we   = 8'h00;
    bram_addr = '0;
    bram_din  = '0;
    if (w_acc_bc) begin
      bram_en   = 1'b1;
      bram_we   = bc_we;
      bram_addr = bc_addr;
      bram_din  = bc_din;
    end else if (w_acc_fc) begin
      bram_en   = 1'b1;
      bram_we   = fc_we;
      bram_addr = fc_addr;
      bram_din  = fc_din;
    end
  end

  assign owner    = r_state;
  assign bc_ready = (r_state == OWN_BC);
  assign fc_ready = (r_state == OWN_FC);
  assign bc_rvld  = r_rd_bc_p1;
  assign fc_rvld  = r_rd_fc_p1;
  assign bc_dout  = bram_dout;
  assign fc_dout  = bram_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
module tb_bram_port_arbiter;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int MB = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          bc_en = 1'b0, fc_en = 1'b0;
  logic [7:0]    bc_we = 8'h00, fc_we = 8'h00;
  logic [AW-1:0] bc_addr = '0, fc_addr = '0;
  logic [DW-1:0] bc_din = '0, fc_din = '0;
  logic          bc_ready, fc_ready, bc_rvld, fc_rvld;
  logic [DW-1:0] bc_dout, fc_dout;
  logic          bram_en;
  logic [7:0]    bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout = '0;
  logic [1:0]    owner;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mem [0:4095];

  always #5 clk = ~clk;

  bram_port_arbiter #(.BRAM_DAT_W(DW), .BRAM_ADDR_W(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .bc_en(bc_en), .bc_we(bc_we), .bc_addr(bc_addr), .bc_din(bc_din),
    .bc_ready(bc_ready), .bc_rvld(bc_rvld), .bc_dout(bc_dout),
    .fc_en(fc_en), .fc_we(fc_we), .fc_addr(fc_addr), .fc_din(fc_din),
    .fc_ready(fc_ready), .fc_rvld(fc_rvld), .fc_dout(fc_dout),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout), .owner(owner)
  );

  // Behavioural BRAM: 1-cycle read latency, byte-enabled writes, reloaded on reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4096; i++) mem[i] = {32'(i) * 32'h9E3779B9, 32'(i) ^ 32'h5A5A0000};
    end else if (bram_en) begin
      if (bram_we == 8'h00) bram_dout <= mem[bram_addr[14:3]];
      else for (int b = 0; b < 8; b++)
        if (bram_we[b]) mem[bram_addr[14:3]][8*b +: 8] = bram_din[8*b +: 8];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic drive_bc(input logic en, input logic [7:0] we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bc_en = en; bc_we = we; bc_addr = a; bc_din = d;
  endtask

  task automatic drive_fc(input logic en, input logic [7:0] we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    fc_en = en; fc_we = we; fc_addr = a; fc_din = d;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    drive_bc(1'b0, 8'h00, '0, '0);
    drive_fc(1'b0, 8'h00, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Waits (bounded) for side's acceptance; returns at the negedge of the accept cycle.
  task automatic wait_accept(input bit side_fc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (side_fc ? (fc_ready && fc_en) : (bc_ready && bc_en)) begin
        ok = 1'b1;
        break;
      end
      next_cycle();
    end
  endtask

  task automatic test_reset();
    next_cycle();
    rst = 1'b1;
    drive_bc(1'($urandom), 8'($urandom), 32'($urandom), {$urandom, $urandom});
    drive_fc(1'($urandom), 8'($urandom), 32'($urandom), {$urandom, $urandom});
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (owner !== 2'b00) begin n_err++; $display("FAIL rst_owner: got %b want 00", owner); end
    n_cmp++; if ({bc_ready, fc_ready} !== 2'b00) begin n_err++; $display("FAIL rst_ready: got %b want 00", {bc_ready, fc_ready}); end
    n_cmp++; if ({bc_rvld, fc_rvld} !== 2'b00) begin n_err++; $display("FAIL rst_rvld: got %b want 00", {bc_rvld, fc_rvld}); end
    n_cmp++; if ({bram_en, bram_we, bram_addr, bram_din} !== '0) begin n_err++;
      $display("FAIL rst_bram: got en=%b we=%h addr=%h din=%h want all 0", bram_en, bram_we, bram_addr, bram_din); end
    next_cycle();
    rst = 1'b0;
    drive_bc(1'b0, 8'h00, '0, '0);
    drive_fc(1'b0, 8'h00, '0, '0);
    @(negedge clk);
    n_cmp++; if (owner !== 2'b00) begin n_err++; $display("FAIL rst_idle_after: got %b want 00", owner); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive_bc(1'b1, 8'h00, 32'h100, '0);
    drive_fc(1'b1, 8'h00, 32'h200, '0);
    @(negedge clk);
    n_cmp++; if ({owner, bram_en} !== 3'b000) begin n_err++; $display("FAIL sim_idle: got owner=%b en=%b want 00/0", owner, bram_en); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if ({owner, bc_ready, fc_ready} !== 4'b0110) begin n_err++;
      $display("FAIL sim_grant_bc: got owner=%b rdy=%b%b want 01/10", owner, bc_ready, fc_ready); end
    n_cmp++; if ({bram_en, bram_addr} !== {1'b1, 32'h100}) begin n_err++;
      $display("FAIL sim_bus_bc: got en=%b addr=%h want 1/100", bram_en, bram_addr); end
    repeat (2) next_cycle();
    drive_bc(1'b0, 8'h00, '0, '0);
    @(negedge clk);
    n_cmp++; if ({owner, bram_en} !== 3'b010) begin n_err++; $display("FAIL sim_bc_drop: got owner=%b en=%b want 01/0", owner, bram_en); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if ({owner, fc_ready, bram_addr} !== {2'b10, 1'b1, 32'h200}) begin n_err++;
      $display("FAIL sim_grant_fc: got owner=%b rdy=%b addr=%h want 10/1/200", owner, fc_ready, bram_addr); end
    next_cycle();
    drive_fc(1'b0, 8'h00, '0, '0);
  endtask

  task automatic test_fc_burst();
    int n_acc = 0, n_rv = 0, last_acc = -1, last_rv = -1, first_bc = -1, beats = 0;
    bit prev_acc = 1'b0, acc;
    logic [DW-1:0] exp_d = '0;
    do_reset();
    drive_fc(1'b1, 8'h00, 32'h0, '0);
    for (int cyc = 0; cyc < 25; cyc++) begin
      @(negedge clk);
      acc = fc_ready && fc_en;
      n_cmp++; if (fc_rvld !== prev_acc) begin n_err++; $display("FAIL burst_rvld c%0d: got %b want %b", cyc, fc_rvld, prev_acc); end
      if (fc_rvld) begin
        n_rv++; last_rv = cyc;
        n_cmp++; if (fc_dout !== exp_d) begin n_err++; $display("FAIL burst_data c%0d: got %h want %h", cyc, fc_dout, exp_d); end
      end
      if (acc) begin n_acc++; last_acc = cyc; exp_d = mem[fc_addr[14:3]]; end
      if (owner == 2'b01 && first_bc < 0) first_bc = cyc;
      prev_acc = acc;
      next_cycle();
      if (cyc == 0) drive_bc(1'b1, 8'h00, 32'h1000, '0);
      if (acc) begin
        beats++;
        if (beats == 20) drive_fc(1'b0, 8'h00, '0, '0);
        else fc_addr = 32'(beats * 8);
      end
    end
    n_cmp++; if (n_acc !== 16) begin n_err++; $display("FAIL burst_beats: got %0d want 16", n_acc); end
    n_cmp++; if (first_bc !== last_acc + 1) begin n_err++; $display("FAIL burst_switch: bc at c%0d, last fc accept c%0d", first_bc, last_acc); end
    n_cmp++; if (n_rv !== 16) begin n_err++; $display("FAIL burst_rvld_cnt: got %0d want 16", n_rv); end
    n_cmp++; if (last_rv !== first_bc) begin n_err++; $display("FAIL burst_last_rvld: got c%0d want c%0d", last_rv, first_bc); end
    drive_bc(1'b0, 8'h00, '0, '0);
    drive_fc(1'b0, 8'h00, '0, '0);
  endtask

  task automatic test_fc_stream();
    int n_acc = 0, n_rv = 0, idx = 0;
    bit prev_acc = 1'b0, acc;
    logic [DW-1:0] exp_d = '0;
    do_reset();
    drive_fc(1'b1, 8'h00, 32'h0, '0);
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      acc = fc_ready && fc_en;
      n_cmp++; if (fc_rvld !== prev_acc) begin n_err++; $display("FAIL stream_rvld c%0d: got %b want %b", cyc, fc_rvld, prev_acc); end
      n_cmp++; if (bc_rvld !== 1'b0) begin n_err++; $display("FAIL stream_bc_rvld c%0d: got %b want 0", cyc, bc_rvld); end
      if (cyc >= 1 && cyc <= 96) begin
        n_cmp++; if (owner !== 2'b10) begin n_err++; $display("FAIL stream_owner c%0d: got %b want 10", cyc, owner); end
      end
      if (fc_rvld) begin
        n_rv++;
        n_cmp++; if (fc_dout !== exp_d) begin n_err++; $display("FAIL stream_data c%0d: got %h want %h", cyc, fc_dout, exp_d); end
      end
      if (acc) begin n_acc++; exp_d = mem[fc_addr[14:3]]; end
      prev_acc = acc;
      next_cycle();
      if (acc) begin
        idx++;
        if (idx == 96) drive_fc(1'b0, 8'h00, '0, '0);
        else fc_addr = 32'(idx * 8);
      end
    end
    n_cmp++; if (n_acc !== 96) begin n_err++; $display("FAIL stream_acc_cnt: got %0d want 96", n_acc); end
    n_cmp++; if (n_rv !== 96) begin n_err++; $display("FAIL stream_rvld_cnt: got %0d want 96", n_rv); end
  endtask

  task automatic test_write_read();
    bit ok;
    do_reset();
    // Full write by bc, read back by fc.
    drive_bc(1'b1, 8'hFF, 32'h3400, 64'hDEADBEEF_CAFEF00D);
    wait_accept(1'b0, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL wr_accept: got none want accept"); end
    n_cmp++; if ({bram_en, bram_we, bram_addr, bram_din} !== {1'b1, 8'hFF, 32'h3400, 64'hDEADBEEF_CAFEF00D}) begin n_err++;
      $display("FAIL wr_bus: got en=%b we=%h addr=%h din=%h want 1/ff/3400/deadbeefcafef00d", bram_en, bram_we, bram_addr, bram_din); end
    next_cycle();
    drive_bc(1'b0, 8'h00, '0, '0);
    drive_fc(1'b1, 8'h00, 32'h3400, '0);
    @(negedge clk);
    n_cmp++; if (bc_rvld !== 1'b0) begin n_err++; $display("FAIL wr_no_resp: got %b want 0", bc_rvld); end
    wait_accept(1'b1, ok);
    n_cmp++; if (!ok || bram_we !== 8'h00) begin n_err++; $display("FAIL rd_accept: ok=%b we=%h want 1/00", ok, bram_we); end
    next_cycle();
    drive_fc(1'b0, 8'h00, '0, '0);
    @(negedge clk);
    n_cmp++; if ({fc_rvld, fc_dout} !== {1'b1, 64'hDEADBEEF_CAFEF00D}) begin n_err++;
      $display("FAIL rd_data: got rvld=%b dout=%h want 1/deadbeefcafef00d", fc_rvld, fc_dout); end
    // Partial write: only the low four bytes change.
    next_cycle();
    drive_bc(1'b1, 8'h0F, 32'h3400, 64'h11111111_22222222);
    wait_accept(1'b0, ok);
    n_cmp++; if (!ok || bram_we !== 8'h0F) begin n_err++; $display("FAIL pwr_we: ok=%b we=%h want 1/0f", ok, bram_we); end
    next_cycle();
    drive_bc(1'b0, 8'h00, '0, '0);
    drive_fc(1'b1, 8'h00, 32'h3400, '0);
    wait_accept(1'b1, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL prd_accept: got none want accept"); end
    next_cycle();
    drive_fc(1'b0, 8'h00, '0, '0);
    @(negedge clk);
    n_cmp++; if ({fc_rvld, fc_dout} !== {1'b1, 64'hDEADBEEF_22222222}) begin n_err++;
      $display("FAIL prd_data: got rvld=%b dout=%h want 1/deadbeef22222222", fc_rvld, fc_dout); end
  endtask

  task automatic test_reset_midread();
    do_reset();
    drive_bc(1'b1, 8'h00, 32'h40, '0);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bram_en !== 1'b1) begin n_err++; $display("FAIL mr_accept: got en=%b want 1", bram_en); end
    next_cycle();
    rst = 1'b0;
    drive_fc(1'b1, 8'h00, 32'h80, '0);
    @(negedge clk);
    n_cmp++; if ({bc_rvld, fc_rvld, owner, bram_en} !== 5'b00000) begin n_err++;
      $display("FAIL mr_after_rst: got rvld=%b%b owner=%b en=%b want 00/00/0", bc_rvld, fc_rvld, owner, bram_en); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if ({owner, bc_ready} !== 3'b011) begin n_err++; $display("FAIL mr_bc_wins: got owner=%b rdy=%b want 01/1", owner, bc_ready); end
    next_cycle();
    drive_bc(1'b0, 8'h00, '0, '0);
    drive_fc(1'b0, 8'h00, '0, '0);
  endtask

  task automatic test_random();
    int m_own = 0, m_last = 2, m_tb = 0, n_own, oth, contested = 0, p_bc = 70, p_fc = 70;
    bit m_rv_b = 0, m_rv_f = 0, acc_b = 0, acc_f = 0, me_en, oth_en;
    logic [DW-1:0] m_d_b = '0, m_d_f = '0;
    logic [1:0] prev_owner = 2'b00;
    logic [DW+AW+8:0] exp_bus;
    do_reset();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      next_cycle();
      if (cyc % 256 == 0) begin
        case ($urandom_range(0, 2)) 0: p_bc = 20; 1: p_bc = 70; default: p_bc = 97; endcase
        case ($urandom_range(0, 2)) 0: p_fc = 20; 1: p_fc = 70; default: p_fc = 97; endcase
      end
      // Requesters hold a request until it is accepted.
      if (!bc_en || acc_b)
        drive_bc($urandom_range(0, 99) < p_bc, ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
                 32'($urandom_range(0, 4095)) << 3, {$urandom, $urandom});
      if (!fc_en || acc_f)
        drive_fc($urandom_range(0, 99) < p_fc, ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
                 32'($urandom_range(0, 4095)) << 3, {$urandom, $urandom});
      @(negedge clk);
      acc_b = (m_own == 1) && bc_en;
      acc_f = (m_own == 2) && fc_en;
      exp_bus = '0;
      if (acc_b) exp_bus = {1'b1, bc_we, bc_addr, bc_din};
      else if (acc_f) exp_bus = {1'b1, fc_we, fc_addr, fc_din};
      n_cmp++; if ({owner, bc_ready, fc_ready} !== {2'(m_own), m_own == 1, m_own == 2}) begin n_err++;
        $display("FAIL rnd_owner c%0d: got %b rdy=%b%b want %0d", cyc, owner, bc_ready, fc_ready, m_own); end
      n_cmp++; if ({bram_en, bram_we, bram_addr, bram_din} !== exp_bus) begin n_err++;
        $display("FAIL rnd_bus c%0d: got %h want %h", cyc, {bram_en, bram_we, bram_addr, bram_din}, exp_bus); end
      n_cmp++; if ({bc_rvld, fc_rvld} !== {m_rv_b, m_rv_f}) begin n_err++;
        $display("FAIL rnd_rvld c%0d: got %b%b want %b%b", cyc, bc_rvld, fc_rvld, m_rv_b, m_rv_f); end
      if (m_rv_b) begin
        n_cmp++; if (bc_dout !== m_d_b) begin n_err++; $display("FAIL rnd_bc_data c%0d: got %h want %h", cyc, bc_dout, m_d_b); end
      end
      if (m_rv_f) begin
        n_cmp++; if (fc_dout !== m_d_f) begin n_err++; $display("FAIL rnd_fc_data c%0d: got %h want %h", cyc, fc_dout, m_d_f); end
      end
      n_cmp++; if ((bc_ready && fc_ready) || (bc_rvld && fc_rvld)) begin n_err++;
        $display("FAIL rnd_exclusive c%0d: got rdy=%b%b rvld=%b%b want at most one of each", cyc, bc_ready, fc_ready, bc_rvld, fc_rvld); end
      // Tenure length as seen on the DUT pins while the other side waits.
      if (owner != prev_owner) contested = 0;
      if ((bc_ready && bc_en && fc_en) || (fc_ready && fc_en && bc_en)) begin
        contested++;
        n_cmp++; if (contested > MB) begin n_err++; $display("FAIL rnd_tenure c%0d: got %0d beats want <= %0d", cyc, contested, MB); end
      end
      prev_owner = owner;
      // Reference model advance.
      m_rv_b = acc_b && (bc_we == 8'h00);
      m_rv_f = acc_f && (fc_we == 8'h00);
      if (m_rv_b) m_d_b = mem[bc_addr[14:3]];
      if (m_rv_f) m_d_f = mem[fc_addr[14:3]];
      if (m_own == 0) begin
        if (bc_en && fc_en) n_own = (m_last == 1) ? 2 : 1;
        else if (bc_en) n_own = 1;
        else if (fc_en) n_own = 2;
        else n_own = 0;
      end else begin
        me_en  = (m_own == 1) ? bc_en : fc_en;
        oth_en = (m_own == 1) ? fc_en : bc_en;
        oth    = 3 - m_own;
        if (!me_en) n_own = oth_en ? oth : 0;
        else if (m_tb >= MB - 1 && oth_en) n_own = oth;
        else n_own = m_own;
      end
      if (n_own != m_own) begin
        if (m_own != 0) m_last = m_own;
        m_tb = 0;
      end else if (acc_b || acc_f) begin
        m_tb++;
      end
      m_own = n_own;
    end
    drive_bc(1'b0, 8'h00, '0, '0);
    drive_fc(1'b0, 8'h00, '0, '0);
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_fc_burst();
    test_fc_stream();
    test_write_read();
    test_reset_midread();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
